// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM arbiter slice: sequencer state encoding
// and the default DRAM geometry used by the core memory interface.
package dram_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: scans upward from last_grant+1 (wrapping) and
// remembers the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    localparam int IDX_W = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 grant_en,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [IDX_W-1:0]     last_grant
);

    logic found;

    always_comb begin
        logic [IDX_W-1:0] cand;
        found     = 1'b0;
        grant_idx = last_grant;
        cand      = '0;
        // Offsets 1..NUM_CORES, so the previous winner is considered last.
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_CORES);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_onehot
        assign grant[gi] = found && (grant_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_CORES - 1);
        end else if (grant_en && found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Serialises NUM_CORES core memory ports onto one single-port DRAM with a
// registered read; one transaction in flight, round-robin between cores.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    localparam int IDX_W    = $clog2(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_done,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    arb_state_t             state_reg;
    logic                   we_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [DATA_W-1:0]      wdata_reg;
    logic [NUM_CORES-1:0]   granted_reg;

    logic [NUM_CORES-1:0]   arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic [IDX_W-1:0]       last_grant;
    logic                   grant_en;

    // Requests are only looked at while idle; mid-transaction changes are ignored.
    assign grant_en = (state_reg == IDLE) && (|core_req);

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .req        (core_req),
        .grant_en   (grant_en),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .last_grant (last_grant)
    );

    assign grant_id  = last_grant;
    assign busy      = (state_reg != IDLE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    // The write strobe must be confined to ACCESS so the DRAM writes exactly once.
    assign mem_we    = we_reg && (state_reg == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            core_done   <= '0;
            core_rdata  <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            granted_reg <= '0;
        end else begin
            core_done <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_en) begin
                        we_reg      <= core_we[arb_idx];
                        addr_reg    <= core_addr[arb_idx*ADDR_W +: ADDR_W];
                        wdata_reg   <= core_wdata[arb_idx*DATA_W +: DATA_W];
                        granted_reg <= arb_grant;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_reg) begin
                        core_done <= granted_reg;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    core_rdata <= mem_rdata;
                    core_done  <= granted_reg;
                    state_reg  <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: DRAM model with registered read plus a shadow memory
// and round-robin order model that predict grants, data and latency.
module tb_dram_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_done;
    logic [DW-1:0]     core_rdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic [DW-1:0]     dram    [0:65535];
    logic [DW-1:0]     ref_mem [0:65535];

    int                n_tests = 0;
    int                n_fail  = 0;
    int                model_last;
    logic [DW-1:0]     model_rdata;

    dram_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .busy       (busy),
        .grant_id   (grant_id),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'((a * 40503) ^ 16'h1234);
    endfunction

    // DRAM: no reset, read-first, one-cycle registered read.
    initial begin
        for (int i = 0; i < 65536; i++) dram[i] = init_word(i);
        dram[16'hFF7A] = 16'd5;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_we) dram[mem_addr] <= mem_wdata;
            mem_rdata <= dram[mem_addr];
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        core_req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last  = NC - 1;
        model_rdata = '0;
    endtask

    // Drives one batch of simultaneous requests, each held until its done pulse.
    task automatic run_round(input logic [NC-1:0] mask, input logic [NC-1:0] we,
                             input logic [NC*AW-1:0] addrs, input logic [NC*DW-1:0] wdatas,
                             input string tag);
        int order[$];
        logic [NC-1:0] pend;
        int p, cyc, idx, nwr_seen, nwr_exp, lat_exp;
        bit first;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        pend = mask;
        p = model_last;
        while (pend != 0) begin
            for (int k = 1; k <= NC; k++) begin
                if (pend[(p + k) % NC]) begin
                    p = (p + k) % NC;
                    pend[p] = 1'b0;
                    order.push_back(p);
                    break;
                end
            end
        end
        nwr_exp  = $countones(mask & we);
        lat_exp  = we[order[0]] ? 2 : 3;
        core_we    = we;
        core_addr  = addrs;
        core_wdata = wdatas;
        core_req   = mask;
        cyc = 0;
        first = 1'b1;
        nwr_seen = 0;
        while (order.size() > 0 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            idx = order[0];
            a  = addrs[idx*AW +: AW];
            wd = wdatas[idx*DW +: DW];
            if (mem_we) begin
                nwr_seen++;
                n_tests++;
                if (mem_addr !== a || mem_wdata !== wd) begin
                    n_fail++;
                    $display("FAIL %s wr_port: addr=%h data=%h, required addr=%h data=%h", tag, mem_addr, mem_wdata, a, wd);
                end
            end
            if (core_done != 0) begin
                n_tests++;
                if (core_done !== (NC'(1) << idx) || grant_id !== 2'(idx) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s done: done=%b grant_id=%0d busy=%b, required done=%b grant_id=%0d busy=1",
                             tag, core_done, grant_id, busy, NC'(1) << idx, idx);
                end
                if (first) begin
                    n_tests++;
                    if (cyc != lat_exp) begin
                        n_fail++;
                        $display("FAIL %s latency: %0d cycles, required %0d", tag, cyc, lat_exp);
                    end
                    first = 1'b0;
                end
                if (we[idx]) ref_mem[a] = wd;
                else model_rdata = ref_mem[a];
                n_tests++;
                if (core_rdata !== model_rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata: core%0d got %h, required %h", tag, idx, core_rdata, model_rdata);
                end
                $display("[TB] %s: core%0d %s addr=%h data=%h cycle=%0d", tag, idx, we[idx] ? "wr" : "rd",
                         a, we[idx] ? wd : model_rdata, cyc);
                core_req[idx] = 1'b0;
                model_last = idx;
                void'(order.pop_front());
            end
        end
        if (order.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d transactions outstanding, required 0", tag, order.size());
        end
        core_req = '0;
        n_tests++;
        if (nwr_seen != nwr_exp) begin
            n_fail++;
            $display("FAIL %s wr_count: %0d write cycles, required %0d", tag, nwr_seen, nwr_exp);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (busy !== 1'b0 || grant_id !== 2'd3 || core_done !== '0 || core_rdata !== '0 ||
            mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b grant_id=%0d done=%b rdata=%h we=%b addr=%h wdata=%h, required all 0 and grant_id=3",
                     busy, grant_id, core_done, core_rdata, mem_we, mem_addr, mem_wdata);
        end
        $display("[TB] reset: busy=%b grant_id=%0d", busy, grant_id);
    endtask

    task automatic test_single_read();
        logic [NC*AW-1:0] a = '0;
        a[1*AW +: AW] = 16'hFF7A;
        run_round(4'b0010, 4'b0000, a, '0, "single_read");
    endtask

    task automatic test_write_read();
        logic [NC*AW-1:0] a = '0;
        logic [NC*DW-1:0] d = '0;
        a[0 +: AW] = 16'd10;
        d[0 +: DW] = 16'h00AA;
        run_round(4'b0001, 4'b0001, a, d, "write");
        run_round(4'b0001, 4'b0000, a, '0, "read_back");
    endtask

    task automatic test_contention();
        logic [NC*AW-1:0] a;
        do_reset();
        for (int i = 0; i < NC; i++) a[i*AW +: AW] = AW'(16'h0100 + i * 3);
        run_round(4'b1111, 4'b0000, a, '0, "contention");
    endtask

    task automatic test_fairness();
        int expected[4] = '{2, 3, 2, 3};
        int served_cnt[NC] = '{default: 0};
        int k = 0;
        int cyc = 0;
        int idx;
        logic [AW-1:0] ad;
        core_we = '0;
        core_addr = '0;
        core_addr[2*AW +: AW] = 16'h0200;
        core_addr[3*AW +: AW] = 16'h0300;
        core_req = 4'b0100;
        @(posedge clk);
        #1;
        core_req[3] = 1'b1;
        while (k < 4 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (core_done != 0) begin
                idx = expected[k];
                ad = core_addr[idx*AW +: AW];
                model_rdata = ref_mem[ad];
                n_tests++;
                if (core_done !== (NC'(1) << idx) || core_rdata !== model_rdata) begin
                    n_fail++;
                    $display("FAIL fairness #%0d: done=%b rdata=%h, required done=%b rdata=%h",
                             k, core_done, core_rdata, NC'(1) << idx, model_rdata);
                end
                $display("[TB] fairness: core%0d rd addr=%h data=%h", idx, ad, model_rdata);
                served_cnt[idx]++;
                if (served_cnt[idx] == 2) core_req[idx] = 1'b0;
                model_last = idx;
                k++;
            end
        end
        core_req = '0;
        if (k < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL fairness timeout: %0d served, required 4", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [NC-1:0] mask, we;
        logic [NC*AW-1:0] a;
        logic [NC*DW-1:0] d;
        for (int r = 0; r < 25; r++) begin
            mask = NC'($urandom_range(1, 15));
            we   = NC'($urandom);
            for (int i = 0; i < NC; i++) begin
                a[i*AW +: AW] = AW'($urandom_range(0, 7));
                d[i*DW +: DW] = DW'($urandom);
            end
            run_round(mask, we, a, d, "random");
        end
    endtask

    task automatic test_reset_mid_read();
        logic [NC*AW-1:0] a = '0;
        core_we = '0;
        core_addr = '0;
        core_addr[2*AW +: AW] = 16'h0003;
        core_req = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        core_req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || grant_id !== 2'd3 || core_done !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_read: busy=%b grant_id=%0d done=%b, required busy=0 grant_id=3 done=0",
                     busy, grant_id, core_done);
        end
        model_last  = NC - 1;
        model_rdata = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (core_done !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_read spurious_done: done=%b, required 0", core_done);
            end
        end
        $display("[TB] reset_mid_read: aborted, busy=%b grant_id=%0d", busy, grant_id);
        a[0 +: AW] = 16'h0004;
        run_round(4'b0001, 4'b0000, a, '0, "after_reset");
    endtask

    task automatic test_reset_write_access();
        logic [NC*AW-1:0] a = '0;
        core_we = 4'b0010;
        core_addr = '0;
        core_addr[1*AW +: AW] = 16'h0020;
        core_wdata = '0;
        core_wdata[1*DW +: DW] = 16'hBEEF;
        core_req = 4'b0010;
        @(posedge clk);
        #1;
        rst = 1'b1;
        core_req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_mem[16'h0020] = 16'hBEEF;
        n_tests++;
        if (dram[16'h0020] !== 16'hBEEF || busy !== 1'b0 || core_done !== '0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_write: mem=%h busy=%b done=%b we=%b, required mem=beef busy=0 done=0 we=0",
                     dram[16'h0020], busy, core_done, mem_we);
        end
        $display("[TB] reset_write: mem[0020]=%h busy=%b", dram[16'h0020], busy);
        model_last  = NC - 1;
        model_rdata = '0;
        a[1*AW +: AW] = 16'h0020;
        run_round(4'b0010, 4'b0000, a, '0, "reset_write_readback");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        ref_mem[16'hFF7A] = 16'd5;
        rst = 1'b1;
        core_req = '0;
        core_we = '0;
        core_addr = '0;
        core_wdata = '0;
        model_last = NC - 1;
        model_rdata = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_fairness();
        test_random();
        test_reset_mid_read();
        test_reset_write_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
